unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the instruction-fetch port and the MEM-stage data port of the pipelined CPU.
- Sequences each access with a req/ack handshake toward memory and a req/ready handshake toward each requester.
- Gives data accesses priority over fetch, bounded by a starvation limit.
- Drives a stall line that the pipeline ANDs into its pipeline-register write enables.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants while fetch is waiting before fetch is forced to win.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  the block's single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  32  fetch address; word aligned.
- if_rdata  out  32  fetched instruction; valid while if_ready=1.
- if_ready  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held high until dm_ready.
- dm_wr  in  1  1 = store, 0 = load.
- dm_size  in  2  00 word, 01 half, 10 byte (11 treated as word).
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; valid while dm_ready=1.
- dm_ready  out  1  one-cycle data completion pulse.
- dm_err  out  1  misalignment flag; pulses together with dm_ready.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_wr  out  1  memory write enable; qualified by mem_req.
- mem_size  out  2  access size; 00 for fetch.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched store data.
- mem_rdata  in  32  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory completion; may assert in the first cycle mem_req=1.
- pipe_stall  out  1  combinational: (if_req & ~if_ready) | (dm_req & ~dm_ready).

Behaviour:
- Reset: while reset=0 the state is IDLE, and every registered output (mem_req, mem_wr, mem_size, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ready, dm_ready, dm_err) is 0, as is the starvation counter. Reset asserted mid-transaction abandons the access: mem_req drops asynchronously and no ready is issued.
- The FSM has four states: IDLE, IF_BUSY, DM_BUSY, RESP.
- IDLE arbitration, evaluated each cycle:
  - if dm_req & (~if_req | cnt < STARVE_LIMIT): grant data;
  - else if if_req: grant fetch;
  - else stay in IDLE.
- Grant, taken at the next edge:
  - Latch address, size, write enable and wdata into the mem_* registers.
  - For a fetch grant, force mem_wr=0 and mem_size=00.
  - Set mem_req=1 and go to IF_BUSY or DM_BUSY.
- Misaligned data request: half with addr[0]=1, or word with addr[1:0]≠0.
  - No memory access is made; go straight from IDLE to RESP.
  - dm_ready=1 and dm_err=1 in RESP; dm_rdata holds its previous value.
- IF_BUSY / DM_BUSY: mem_req and the latched fields stay constant until mem_ack=1. Requester inputs are ignored while busy.
- On a sampled mem_ack, at the next edge:
  - mem_req=0, state → RESP.
  - A fetch captures mem_rdata into if_rdata and asserts if_ready.
  - A data load captures mem_rdata into dm_rdata and asserts dm_ready.
  - A data store asserts dm_ready only; dm_rdata is unchanged.
- RESP lasts exactly one cycle and always returns to IDLE; the ready/err pulses clear on that edge. No grant is made in RESP, which prevents re-issuing a request the requester is about to drop.
- Latency: request at cycle 0 → mem_req at cycle 1 → with mem_ack at cycle 1, ready at cycle 2 → IDLE at cycle 3. Best-case throughput is one access per 3 cycles.
- Starvation counter:
  - increments (saturating at STARVE_LIMIT) on each data grant made while if_req=1;
  - clears on any fetch grant;
  - holds on a data grant made with if_req=0.
- Requester dropping req mid-access: the access still completes and ready still pulses; the requester ignores it.
- Sub-word lane alignment and extension are the memory's and write-back's job; the arbiter passes mem_size and the address through unmodified.

Test Plan:
- Reset with mem_req high mid-DM_BUSY → mem_req=0 immediately; IDLE, all outputs 0 after release; no ready pulse.
- Lone fetch, if_addr=0x40, memory acks on the first mem_req cycle with 0x8C220004 → mem_req high cycle 1 only, if_ready=1 with if_rdata=0x8C220004 at cycle 2, pipe_stall high cycles 0-1.
- Simultaneous if_req and dm_req (load 0x100, mem returns 0xDEADBEEF, 3-cycle ack) → data granted first with dm_rdata=0xDEADBEEF; fetch granted in the IDLE following RESP.
- dm_req held continuously with back-to-back loads while if_req is high, STARVE_LIMIT=4 → exactly 4 data grants, then a fetch grant; counter returns to 0.
- Store half to 0x203 → no mem_req; dm_ready=1 and dm_err=1 one cycle after request; dm_rdata unchanged.
- Store word 0x12345678 to 0x10 with ack delayed 5 cycles → mem_addr/mem_wdata/mem_wr/mem_size stable all 5 cycles; single dm_ready pulse; dm_err=0.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// unified_mem_arbiter_if : fetch port, data port and memory port bundle
// Rev 1.0 - initial release
// ============================================================================
interface unified_mem_arbiter_if;
  // Instruction-fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  // MEM-stage data requester
  logic        dm_req;
  logic        dm_wr;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        dm_err;
  // Shared memory
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  // Pipeline hold
  logic        pipe_stall;

  // Arbiter view: serves the requesters and masters the memory.
  modport master (
    input  if_req, if_addr,
    output if_rdata, if_ready,
    input  dm_req, dm_wr, dm_size, dm_addr, dm_wdata,
    output dm_rdata, dm_ready, dm_err,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output pipe_stall
  );

  // Environment view: pipeline requesters plus the memory itself.
  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_ready,
    output dm_req, dm_wr, dm_size, dm_addr, dm_wdata,
    input  dm_rdata, dm_ready, dm_err,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  pipe_stall
  );
endinterface
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// unified_mem_arbiter : shares one variable-latency memory between fetch and
//                       data ports; data wins unless fetch has starved.
// Rev 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  unified_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_BUSY = 2'd1,
    S_DM_BUSY = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  state_e            state_q,     state_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_wr_q,    mem_wr_d;
  logic [1:0]        mem_size_q,  mem_size_d;
  logic [31:0]       mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_rdata_q,  if_rdata_d;
  logic [31:0]       dm_rdata_q,  dm_rdata_d;
  logic              if_ready_q,  if_ready_d;
  logic              dm_ready_q,  dm_ready_d;
  logic              dm_err_q,    dm_err_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic              dm_misaligned;
  logic              grant_dm;
  logic              grant_if;

  // Byte accesses can never be misaligned; size 11 behaves as a word.
  always_comb begin
    dm_misaligned = 1'b0;
    case (bus.dm_size)
      2'b01:   dm_misaligned = bus.dm_addr[0];
      2'b10:   dm_misaligned = 1'b0;
      default: dm_misaligned = (bus.dm_addr[1:0] != 2'b00);
    endcase
  end

  assign grant_dm = bus.dm_req & (~bus.if_req | (cnt_q < STARVE_MAX));
  assign grant_if = bus.if_req & ~grant_dm;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    dm_err_d    = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (grant_dm) begin
          if (bus.if_req && (cnt_q != STARVE_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (dm_misaligned) begin
            // Rejected without touching memory; the error completes in RESP.
            dm_ready_d = 1'b1;
            dm_err_d   = 1'b1;
            state_d    = S_RESP;
          end else begin
            mem_req_d   = 1'b1;
            mem_wr_d    = bus.dm_wr;
            mem_size_d  = bus.dm_size;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
            state_d     = S_DM_BUSY;
          end
        end else if (grant_if) begin
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_size_d  = 2'b00;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = mem_wdata_q;
          state_d     = S_IF_BUSY;
        end
      end

      S_IF_BUSY: begin
        if (bus.mem_ack) begin
          mem_req_d  = 1'b0;
          if_rdata_d = bus.mem_rdata;
          if_ready_d = 1'b1;
          state_d    = S_RESP;
        end
      end

      S_DM_BUSY: begin
        if (bus.mem_ack) begin
          mem_req_d  = 1'b0;
          dm_ready_d = 1'b1;
          if (!mem_wr_q) begin
            dm_rdata_d = bus.mem_rdata;
          end
          state_d    = S_RESP;
        end
      end

      // One dead cycle so a requester dropping req is never re-granted.
      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      dm_rdata_q  <= 32'h0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      dm_err_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      dm_err_q    <= dm_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_size   = mem_size_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_ready   = if_ready_q;
  assign bus.dm_rdata   = dm_rdata_q;
  assign bus.dm_ready   = dm_ready_q;
  assign bus.dm_err     = dm_err_q;
  assign bus.pipe_stall = (bus.if_req & ~if_ready_q) | (bus.dm_req & ~dm_ready_q);

  a_resp_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_RESP) |=> (state_q == S_IDLE));

  a_busy_fields_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req_q && !bus.mem_ack) |=>
      (mem_req_q && $stable(mem_addr_q) && $stable(mem_wdata_q) &&
       $stable(mem_wr_q) && $stable(mem_size_q)));

  a_ready_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(if_ready_q && dm_ready_q));

  a_err_with_ready: assert property (@(posedge clk) disable iff (!rst_n)
    dm_err_q |-> dm_ready_q);

  a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= STARVE_MAX);

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_unified_mem_arbiter : vector table plus directed corner sequences, with
//                          per-port expected-result queues.
// Rev 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  unified_mem_arbiter_if bus ();

  unified_mem_arbiter #(
    .STARVE_LIMIT (4),
    .CNT_W        (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    bit          is_dm;
    bit          wr;
    bit [1:0]    size;
    bit [31:0]   addr;
    bit [31:0]   wdata;
    int          delay;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NV = 12;

  exp_t        if_q[$];
  exp_t        dm_q[$];
  bit          order_log[$];
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          mem_delay = 1;
  int          mcyc      = 0;
  int          ack_count = 0;
  logic [31:0] log_addr  = 32'h0;
  logic [31:0] log_wdata = 32'h0;
  logic        log_wr    = 1'b0;
  logic [1:0]  log_size  = 2'b00;
  logic [31:0] last_dm   = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40)  return 32'h8C220004;
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [31:0] pack_log();
    logic [7:0] pat;
    pat = 8'h0;
    foreach (order_log[i]) pat = {pat[6:0], order_log[i]};
    return (32'(order_log.size()) << 16) | {24'h0, pat};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: acks in the mem_delay-th cycle that mem_req is seen high.
  always @(posedge clk) begin
    #1;
    if (bus.mem_req && !bus.mem_ack) begin
      mcyc++;
      if (mcyc >= mem_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_word(bus.mem_addr);
        log_addr      = bus.mem_addr;
        log_wdata     = bus.mem_wdata;
        log_wr        = bus.mem_wr;
        log_size      = bus.mem_size;
        ack_count++;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'hBAD0BAD0;
      mcyc          = 0;
    end
  end

  // Completion monitor: every ready pulse must match a queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.if_ready) begin
        order_log.push_back(1'b0);
        if (if_q.size() == 0) begin
          chk("if_ready_unexpected", {31'h0, bus.if_ready}, 32'h0);
        end else begin
          e = if_q.pop_front();
          chk("if_rdata", bus.if_rdata, e.rdata);
        end
      end
      if (bus.dm_ready) begin
        order_log.push_back(1'b1);
        if (dm_q.size() == 0) begin
          chk("dm_ready_unexpected", {31'h0, bus.dm_ready}, 32'h0);
        end else begin
          e = dm_q.pop_front();
          chk("dm_rdata", bus.dm_rdata, e.rdata);
          chk("dm_err", {31'h0, bus.dm_err}, {31'h0, e.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[NV];
    vec_t        v;
    int          n;
    int          acks0;
    int          peak;
    logic [31:0] r;

    vecs[0]  = '{0, 0, 2'b00, 32'h0000_0044, 32'h0,         2, 0, 4};
    vecs[1]  = '{1, 0, 2'b00, 32'h0000_0104, 32'h0,         1, 0, 3};
    vecs[2]  = '{1, 0, 2'b01, 32'h0000_0106, 32'h0,         2, 0, 4};
    vecs[3]  = '{1, 0, 2'b10, 32'h0000_0107, 32'h0,         1, 0, 3};
    vecs[4]  = '{1, 0, 2'b01, 32'h0000_0105, 32'h0,         1, 1, 2};
    vecs[5]  = '{1, 1, 2'b00, 32'h0000_0102, 32'h0000_00A1, 1, 1, 2};
    vecs[6]  = '{1, 0, 2'b11, 32'h0000_010A, 32'h0,         1, 1, 2};
    vecs[7]  = '{1, 0, 2'b11, 32'h0000_010C, 32'h0,         1, 0, 3};
    vecs[8]  = '{1, 1, 2'b10, 32'h0000_0201, 32'h0000_0055, 3, 0, 5};
    vecs[9]  = '{1, 1, 2'b00, 32'h0000_0208, 32'hFEEDFACE,  2, 0, 4};
    vecs[10] = '{0, 0, 2'b00, 32'h0000_0048, 32'h0,         4, 0, 6};
    vecs[11] = '{1, 0, 2'b01, 32'h0000_010E, 32'h0,         1, 0, 3};

    bus.if_req   = 1'b0;
    bus.if_addr  = 32'h0;
    bus.dm_req   = 1'b0;
    bus.dm_wr    = 1'b0;
    bus.dm_size  = 2'b00;
    bus.dm_addr  = 32'h0;
    bus.dm_wdata = 32'h0;

    // ---------------- power-on reset ----------------
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req",    {31'h0, bus.mem_req},  32'h0);
    chk("rst_mem_wr",     {31'h0, bus.mem_wr},   32'h0);
    chk("rst_mem_size",   {30'h0, bus.mem_size}, 32'h0);
    chk("rst_mem_addr",   bus.mem_addr,          32'h0);
    chk("rst_mem_wdata",  bus.mem_wdata,         32'h0);
    chk("rst_if_rdata",   bus.if_rdata,          32'h0);
    chk("rst_dm_rdata",   bus.dm_rdata,          32'h0);
    chk("rst_if_ready",   {31'h0, bus.if_ready}, 32'h0);
    chk("rst_dm_ready",   {31'h0, bus.dm_ready}, 32'h0);
    chk("rst_dm_err",     {31'h0, bus.dm_err},   32'h0);
    chk("rst_pipe_stall", {31'h0, bus.pipe_stall}, 32'h0);
    chk("rst_cnt",        32'(dut.cnt_q),        32'h0);
    rst_n = 1'b1;

    // ---------------- reset mid DM_BUSY ----------------
    @(posedge clk); #1;
    mem_delay = 20; acks0 = ack_count;
    bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_size = 2'b00; bus.dm_addr = 32'h700;
    @(negedge clk);
    chk("midrst_c0_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("midrst_c0_stall",   {31'h0, bus.pipe_stall}, 32'h1);
    @(negedge clk);
    chk("midrst_c1_mem_req", {31'h0, bus.mem_req}, 32'h1);
    @(negedge clk);
    chk("midrst_c2_mem_req", {31'h0, bus.mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("midrst_async_drop", {31'h0, bus.mem_req}, 32'h0);
    bus.dm_req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_post_state",    32'(dut.state_q),       32'h0);
    chk("midrst_post_mem_req",  {31'h0, bus.mem_req},   32'h0);
    chk("midrst_post_mem_addr", bus.mem_addr,           32'h0);
    chk("midrst_post_dm_ready", {31'h0, bus.dm_ready},  32'h0);
    chk("midrst_post_dm_rdata", bus.dm_rdata,           32'h0);
    chk("midrst_no_mem_ack",    ack_count,              acks0);

    // ---------------- lone fetch, ack on first mem_req cycle ----------------
    @(posedge clk); #1;
    mem_delay = 1;
    if_q.push_back('{mem_word(32'h40), 1'b0});
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    @(negedge clk);
    chk("fetch_c0_stall",   {31'h0, bus.pipe_stall}, 32'h1);
    chk("fetch_c0_mem_req", {31'h0, bus.mem_req},    32'h0);
    @(negedge clk);
    chk("fetch_c1_mem_req",  {31'h0, bus.mem_req},    32'h1);
    chk("fetch_c1_mem_addr", bus.mem_addr,            32'h40);
    chk("fetch_c1_mem_wr",   {31'h0, bus.mem_wr},     32'h0);
    chk("fetch_c1_mem_size", {30'h0, bus.mem_size},   32'h0);
    chk("fetch_c1_stall",    {31'h0, bus.pipe_stall}, 32'h1);
    @(negedge clk);
    chk("fetch_c2_if_ready", {31'h0, bus.if_ready},   32'h1);
    chk("fetch_c2_if_rdata", bus.if_rdata,            32'h8C220004);
    chk("fetch_c2_mem_req",  {31'h0, bus.mem_req},    32'h0);
    chk("fetch_c2_stall",    {31'h0, bus.pipe_stall}, 32'h0);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("fetch_c3_if_ready", {31'h0, bus.if_ready}, 32'h0);
    chk("fetch_c3_mem_req",  {31'h0, bus.mem_req},  32'h0);

    // ---------------- simultaneous fetch and load ----------------
    @(posedge clk); #1;
    mem_delay = 3;
    order_log.delete();
    dm_q.push_back('{32'hDEADBEEF, 1'b0}); last_dm = 32'hDEADBEEF;
    if_q.push_back('{mem_word(32'h80), 1'b0});
    bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_size = 2'b00; bus.dm_addr = 32'h100;
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    chk("simul_first_addr", bus.mem_addr, 32'h100);
    chk("simul_cnt_after_dm", 32'(dut.cnt_q), 32'h1);
    n = 1;
    while (!bus.dm_ready && n < 40) begin
      @(negedge clk); n++;
    end
    chk("simul_dm_ready_cycle", n, 4);
    @(posedge clk); #1;
    bus.dm_req = 1'b0;
    @(negedge clk);
    chk("simul_idle_mem_req", {31'h0, bus.mem_req}, 32'h0);
    @(negedge clk);
    chk("simul_fetch_mem_req",  {31'h0, bus.mem_req},  32'h1);
    chk("simul_fetch_mem_addr", bus.mem_addr,          32'h80);
    chk("simul_fetch_mem_wr",   {31'h0, bus.mem_wr},   32'h0);
    chk("simul_fetch_cnt",      32'(dut.cnt_q),        32'h0);
    n = 0;
    while (!bus.if_ready && n < 40) begin
      @(negedge clk); n++;
    end
    chk("simul_if_done", {31'h0, bus.if_ready}, 32'h1);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    chk("simul_order", pack_log(), (32'd2 << 16) | 32'h2);

    // ---------------- starvation limit ----------------
    @(posedge clk); #1;
    mem_delay = 1;
    order_log.delete();
    for (int k = 0; k < 4; k++) dm_q.push_back('{mem_word(32'h600), 1'b0});
    last_dm = mem_word(32'h600);
    if_q.push_back('{mem_word(32'h500), 1'b0});
    bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_size = 2'b00; bus.dm_addr = 32'h600;
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    n = 0; peak = 0;
    do begin
      @(negedge clk); n++;
      if (32'(dut.cnt_q) > peak) peak = 32'(dut.cnt_q);
    end while (!bus.if_ready && n < 80);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    @(negedge clk);
    chk("starve_peak_cnt",  peak,                  32'd4);
    chk("starve_order",     pack_log(),            (32'd5 << 16) | 32'h1E);
    chk("starve_cnt_clear", 32'(dut.cnt_q),        32'h0);
    chk("starve_idle",      {31'h0, bus.mem_req},  32'h0);

    // ---------------- misaligned half store ----------------
    @(posedge clk); #1;
    acks0 = ack_count;
    dm_q.push_back('{last_dm, 1'b1});
    bus.dm_req = 1'b1; bus.dm_wr = 1'b1; bus.dm_size = 2'b01;
    bus.dm_addr = 32'h203; bus.dm_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("mis_c0_mem_req",  {31'h0, bus.mem_req},  32'h0);
    chk("mis_c0_dm_ready", {31'h0, bus.dm_ready}, 32'h0);
    @(negedge clk);
    chk("mis_c1_dm_ready", {31'h0, bus.dm_ready}, 32'h1);
    chk("mis_c1_dm_err",   {31'h0, bus.dm_err},   32'h1);
    chk("mis_c1_mem_req",  {31'h0, bus.mem_req},  32'h0);
    chk("mis_c1_dm_rdata", bus.dm_rdata,          last_dm);
    @(posedge clk); #1;
    bus.dm_req = 1'b0;
    @(negedge clk);
    chk("mis_c2_dm_err", {31'h0, bus.dm_err}, 32'h0);
    chk("mis_no_access", ack_count,           acks0);

    // ---------------- word store, ack delayed 5 cycles ----------------
    @(posedge clk); #1;
    mem_delay = 5; acks0 = ack_count;
    dm_q.push_back('{last_dm, 1'b0});
    bus.dm_req = 1'b1; bus.dm_wr = 1'b1; bus.dm_size = 2'b00;
    bus.dm_addr = 32'h10; bus.dm_wdata = 32'h12345678;
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("st5_c%0d_mem_req", c),   {31'h0, bus.mem_req},  32'h1);
      chk($sformatf("st5_c%0d_mem_addr", c),  bus.mem_addr,          32'h10);
      chk($sformatf("st5_c%0d_mem_wdata", c), bus.mem_wdata,         32'h12345678);
      chk($sformatf("st5_c%0d_mem_wr", c),    {31'h0, bus.mem_wr},   32'h1);
      chk($sformatf("st5_c%0d_mem_size", c),  {30'h0, bus.mem_size}, 32'h0);
      chk($sformatf("st5_c%0d_dm_ready", c),  {31'h0, bus.dm_ready}, 32'h0);
      // Inputs wander while busy; the latched fields must not follow.
      bus.dm_addr = 32'hFFFF_FFF0; bus.dm_wdata = 32'h0;
    end
    @(negedge clk);
    chk("st5_c6_dm_ready", {31'h0, bus.dm_ready}, 32'h1);
    chk("st5_c6_mem_req",  {31'h0, bus.mem_req},  32'h0);
    @(posedge clk); #1;
    bus.dm_req = 1'b0;
    @(negedge clk);
    chk("st5_c7_dm_ready", {31'h0, bus.dm_ready}, 32'h0);
    chk("st5_one_access",  ack_count,             acks0 + 1);
    chk("st5_log_wdata",   log_wdata,             32'h12345678);

    // ---------------- vector table ----------------
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(posedge clk); #1;
      mem_delay = v.delay; acks0 = ack_count;
      if (!v.is_dm) begin
        if_q.push_back('{mem_word(v.addr), 1'b0});
        bus.if_req = 1'b1; bus.if_addr = v.addr;
      end else begin
        if (v.exp_err || v.wr) begin
          r = last_dm;
        end else begin
          r = mem_word(v.addr);
          last_dm = r;
        end
        dm_q.push_back('{r, v.exp_err});
        bus.dm_req = 1'b1; bus.dm_wr = v.wr; bus.dm_size = v.size;
        bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
      end
      n = 0;
      do begin
        @(negedge clk); n++;
      end while (!(v.is_dm ? bus.dm_ready : bus.if_ready) && n < 40);
      chk($sformatf("vec%0d_latency", i), n, v.exp_lat);
      @(posedge clk); #1;
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      if (v.exp_err) begin
        chk($sformatf("vec%0d_no_access", i), ack_count, acks0);
      end else begin
        chk($sformatf("vec%0d_one_access", i), ack_count, acks0 + 1);
        chk($sformatf("vec%0d_mem_addr", i), log_addr, v.addr);
        chk($sformatf("vec%0d_mem_wr", i), {31'h0, log_wr}, {31'h0, v.is_dm & v.wr});
        chk($sformatf("vec%0d_mem_size", i), {30'h0, log_size},
            v.is_dm ? {30'h0, v.size} : 32'h0);
        if (v.is_dm && v.wr) chk($sformatf("vec%0d_mem_wdata", i), log_wdata, v.wdata);
      end
    end

    repeat (3) @(negedge clk);
    chk("if_queue_drained", if_q.size(), 32'h0);
    chk("dm_queue_drained", dm_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
